// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the zero-wait instruction memory and fills IF/ID.
// Optional static branch prediction is enabled by defining IF_STATIC_PREDICT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  input  logic        resume_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_misalign_o,
  output logic        ifid_pred_taken_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        misalign_q, misalign_d;
  logic        pred_q, pred_d;

  logic        pc_misaligned;
  logic [31:0] seq_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign seq_pc        = pc_q + 32'd4;

`ifdef IF_STATIC_PREDICT_EN
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        is_back_branch;
  logic        is_jal;

  assign b_imm = {{19{imem_data_i[31]}}, imem_data_i[31], imem_data_i[7],
                  imem_data_i[30:25], imem_data_i[11:8], 1'b0};
  assign j_imm = {{11{imem_data_i[31]}}, imem_data_i[31], imem_data_i[19:12],
                  imem_data_i[20], imem_data_i[30:21], 1'b0};

  // Backward conditional branches (negative offset) and every JAL are taken.
  assign is_back_branch = (imem_data_i[6:0] == 7'b1100011) && imem_data_i[31];
  assign is_jal         = (imem_data_i[6:0] == 7'b1101111);
  assign pred_taken     = is_back_branch || is_jal;
  assign pred_pc        = is_jal ? (pc_q + j_imm) : (pc_q + b_imm);
`else
  assign pred_taken = 1'b0;
  assign pred_pc    = seq_pc;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    ifid_pc_d  = ifid_pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    pred_d     = pred_q;

    if (redirect_i) begin
      pc_d       = redirect_pc_i;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      misalign_d = 1'b0;
      pred_d     = 1'b0;
      if (state_q == ST_BOOT) state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_HALT: if (resume_i) state_d = ST_RUN;
        ST_RUN: begin
          if (halt_i) begin
            state_d    = ST_HALT;
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            misalign_d = 1'b0;
            pred_d     = 1'b0;
          end else if (!stall_i) begin
            valid_d   = 1'b1;
            ifid_pc_d = pc_q;
            if (pc_misaligned) begin
              // A misaligned PC keeps re-emitting the same bubble until EX redirects.
              instr_d    = NOP_INSTR;
              misalign_d = 1'b1;
              pred_d     = 1'b0;
            end else begin
              instr_d    = imem_data_i;
              misalign_d = 1'b0;
              pred_d     = pred_taken;
              pc_d       = pred_taken ? pred_pc : seq_pc;
            end
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      ifid_pc_q  <= 32'h0;
      instr_q    <= NOP_INSTR;
      misalign_q <= 1'b0;
      pred_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      ifid_pc_q  <= ifid_pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
      pred_q     <= pred_d;
    end
  end

  assign imem_addr_o       = {2'b00, pc_q[31:2]};
  assign pc_o              = pc_q;
  assign ifid_valid_o      = valid_q;
  assign ifid_pc_o         = ifid_pc_q;
  assign ifid_instr_o      = instr_q;
  assign ifid_misalign_o   = misalign_q;
  assign ifid_pred_taken_o = pred_q;

endmodule
